kbd_key_decoder: RTL and testbench

Decodes the one-cycle scan-code bytes produced by the PS/2 receiver into per-key held state, one-cycle press/release pulses, and a buffered event stream for the game logic. It handles Set-2 make, break (`F0`) and extended (`E0`) prefixes. It suppresses typematic repeats and drops half-received prefix sequences after a timeout. It sits directly downstream of the receiver's `codeword` output and upstream of the player-control logic.

---
 rtl/kbd_pkg.sv | 81 ++++++++
 rtl/kbd_key_decoder_if.sv | 45 ++++
 rtl/kbd_event_fifo.sv | 81 ++++++++
 rtl/kbd_key_decoder.sv | 173 +++++++++++++++++
 tb/tb_kbd_key_decoder.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/kbd_pkg.sv
// kbd_pkg: shared constants and helpers for the keyboard key decoder.
//   - Set-2 byte codes for the prefixes and the ten game keys
//   - key index constants, NUM_KEYS
//   - prefix FSM state encoding
//   - event field widths and the code-to-index lookup function
package kbd_pkg;

    // Prefix bytes
    localparam logic [7:0] KC_EXT   = 8'hE0;
    localparam logic [7:0] KC_BRK   = 8'hF0;

    // Key codes (arrows are only meaningful after KC_EXT)
    localparam logic [7:0] KC_UP    = 8'h75;
    localparam logic [7:0] KC_DOWN  = 8'h72;
    localparam logic [7:0] KC_LEFT  = 8'h6B;
    localparam logic [7:0] KC_RIGHT = 8'h74;
    localparam logic [7:0] KC_W     = 8'h1D;
    localparam logic [7:0] KC_A     = 8'h1C;
    localparam logic [7:0] KC_S     = 8'h1B;
    localparam logic [7:0] KC_D     = 8'h23;
    localparam logic [7:0] KC_L     = 8'h4B;
    localparam logic [7:0] KC_C     = 8'h21;

    localparam int NUM_KEYS = 10;

    localparam logic [3:0] KI_UP    = 4'd0;
    localparam logic [3:0] KI_DOWN  = 4'd1;
    localparam logic [3:0] KI_LEFT  = 4'd2;
    localparam logic [3:0] KI_RIGHT = 4'd3;
    localparam logic [3:0] KI_W     = 4'd4;
    localparam logic [3:0] KI_A     = 4'd5;
    localparam logic [3:0] KI_S     = 4'd6;
    localparam logic [3:0] KI_D     = 4'd7;
    localparam logic [3:0] KI_L     = 4'd8;
    localparam logic [3:0] KI_C     = 4'd9;

    // Event entry is {is_release, key_index}
    localparam int EVT_IDX_W = 4;
    localparam int EVT_W     = EVT_IDX_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } kbd_state_e;

    typedef struct packed {
        logic                 hit;
        logic [EVT_IDX_W-1:0] idx;
    } key_hit_t;

    // Map a byte to a key index. Arrows match only with ext=1 (bare codes are
    // the keypad); letters match only with ext=0.
    function automatic key_hit_t key_lookup(input logic [7:0] code, input logic ext);
        key_hit_t res;
        res.hit = 1'b1;
        res.idx = 4'd0;
        if (ext) begin
            case (code)
                KC_UP:    res.idx = KI_UP;
                KC_DOWN:  res.idx = KI_DOWN;
                KC_LEFT:  res.idx = KI_LEFT;
                KC_RIGHT: res.idx = KI_RIGHT;
                default:  res.hit = 1'b0;
            endcase
        end else begin
            case (code)
                KC_W:     res.idx = KI_W;
                KC_A:     res.idx = KI_A;
                KC_S:     res.idx = KI_S;
                KC_D:     res.idx = KI_D;
                KC_L:     res.idx = KI_L;
                KC_C:     res.idx = KI_C;
                default:  res.hit = 1'b0;
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/kbd_key_decoder_if.sv
// kbd_key_decoder_if: groups the decoder's data/handshake signals.
//   code_in     : receiver codeword (8'h00 = no byte)
//   key_held    : per-key pressed state
//   key_press   : one-cycle make pulses
//   key_release : one-cycle break pulses
//   event_valid : event FIFO not empty
//   event_data  : FIFO head {is_release, key_index}
//   event_ready : consumer pop request
//   overflow    : sticky event-drop flag
// master = producer/consumer side (receiver + game logic), slave = decoder.
interface kbd_key_decoder_if;
    import kbd_pkg::*;

    logic [7:0]          code_in;
    logic [NUM_KEYS-1:0] key_held;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic                event_valid;
    logic [EVT_W-1:0]    event_data;
    logic                event_ready;
    logic                overflow;

    modport master (
        output code_in,
        output event_ready,
        input  key_held,
        input  key_press,
        input  key_release,
        input  event_valid,
        input  event_data,
        input  overflow
    );

    modport slave (
        input  code_in,
        input  event_ready,
        output key_held,
        output key_press,
        output key_release,
        output event_valid,
        output event_data,
        output overflow
    );

endinterface

// File: rtl/kbd_event_fifo.sv
// kbd_event_fifo: show-ahead FIFO with sticky overflow.
//   i_clk       : clock
//   i_rst_n     : synchronous active-low reset
//   i_push      : write request, i_push_data written when accepted
//   i_pop       : read request, honoured only when not empty
//   o_valid     : FIFO not empty
//   o_data      : head entry (valid while o_valid)
//   o_overflow  : sticky, set when a push is dropped on a full FIFO
// A push on a full FIFO is accepted when a pop happens in the same cycle.
module kbd_event_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_overflow;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;
    logic w_drop;

    // Accept/reject decisions for this cycle's push and pop
    always_comb begin
        w_empty   = (r_count == (AW+1)'(0));
        w_full    = (r_count == FULL_CNT);
        w_do_pop  = i_pop && !w_empty;
        w_do_push = i_push && (!w_full || w_do_pop);
        w_drop    = i_push && w_full && !w_do_pop;
    end

    // Storage, pointers, occupancy and overflow flag
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
            r_wr_ptr   <= {AW{1'b0}};
            r_rd_ptr   <= {AW{1'b0}};
            r_count    <= {(AW+1){1'b0}};
            r_overflow <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_valid    = !w_empty;
    assign o_data     = r_mem[r_rd_ptr];
    assign o_overflow = r_overflow;

endmodule

// File: rtl/kbd_key_decoder.sv
// kbd_key_decoder: Set-2 scan-code decoder for ten game keys.
//   CLK     : system clock (rising edge)
//   RESETN  : synchronous active-low reset
//   bus     : kbd_key_decoder_if.slave (code_in, key_held, key_press,
//             key_release, event_valid, event_data, event_ready, overflow)
// Tracks E0/F0 prefixes, suppresses typematic repeats, abandons a pending
// prefix after TIMEOUT idle cycles, and queues press/release events.
module kbd_key_decoder
    import kbd_pkg::*;
#(
    parameter int TIMEOUT    = 250000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            CLK,
    input  logic            RESETN,
    kbd_key_decoder_if.slave bus
);

    localparam logic [1:0] S_IDLE    = 2'(ST_IDLE);
    localparam logic [1:0] S_EXT     = 2'(ST_EXT);
    localparam logic [1:0] S_BRK     = 2'(ST_BRK);
    localparam logic [1:0] S_EXT_BRK = 2'(ST_EXT_BRK);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_MAX = CW'(TIMEOUT - 1);

    logic [1:0]          r_state;
    logic [CW-1:0]       r_tmo_cnt;
    logic [NUM_KEYS-1:0] r_key_held;
    logic [NUM_KEYS-1:0] r_key_press;
    logic [NUM_KEYS-1:0] r_key_release;

    logic                w_byte;
    logic [1:0]          w_nxt_state;
    logic                w_make;
    logic                w_brk;
    logic                w_ext;
    logic                w_tmo;
    key_hit_t            w_hit;
    logic [NUM_KEYS-1:0] w_key_bit;
    logic                w_do_press;
    logic                w_do_release;
    logic                w_push;
    logic [EVT_W-1:0]    w_push_data;
    logic                w_fifo_valid;
    logic [EVT_W-1:0]    w_fifo_data;
    logic                w_fifo_ovf;

    // Prefix FSM next state and classification of the current byte
    always_comb begin
        w_byte      = (bus.code_in != 8'h00);
        w_tmo       = (r_state != S_IDLE) && (r_tmo_cnt == TMO_MAX);
        w_nxt_state = r_state;
        w_make      = 1'b0;
        w_brk       = 1'b0;
        w_ext       = 1'b0;
        if (w_byte) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.code_in == KC_EXT) begin
                        w_nxt_state = S_EXT;
                    end else if (bus.code_in == KC_BRK) begin
                        w_nxt_state = S_BRK;
                    end else begin
                        w_nxt_state = S_IDLE;
                        w_make      = 1'b1;
                    end
                end
                S_EXT: begin
                    if (bus.code_in == KC_BRK) begin
                        w_nxt_state = S_EXT_BRK;
                    end else if (bus.code_in == KC_EXT) begin
                        w_nxt_state = S_EXT;
                    end else begin
                        w_nxt_state = S_IDLE;
                        w_make      = 1'b1;
                        w_ext       = 1'b1;
                    end
                end
                S_BRK: begin
                    w_nxt_state = S_IDLE;
                    if ((bus.code_in != KC_EXT) && (bus.code_in != KC_BRK)) begin
                        w_brk = 1'b1;
                    end else begin
                        w_brk = 1'b0;
                    end
                end
                S_EXT_BRK: begin
                    w_nxt_state = S_IDLE;
                    if ((bus.code_in != KC_EXT) && (bus.code_in != KC_BRK)) begin
                        w_brk = 1'b1;
                        w_ext = 1'b1;
                    end else begin
                        w_brk = 1'b0;
                    end
                end
                default: w_nxt_state = S_IDLE;
            endcase
        end else if (w_tmo) begin
            w_nxt_state = S_IDLE;
        end else begin
            w_nxt_state = r_state;
        end
    end

    // Key lookup and press/release qualification against held state
    always_comb begin
        w_hit        = key_lookup(bus.code_in, w_ext);
        w_key_bit    = NUM_KEYS'(1) << w_hit.idx;
        w_do_press   = w_make && w_hit.hit && ((r_key_held & w_key_bit) == {NUM_KEYS{1'b0}});
        w_do_release = w_brk  && w_hit.hit && ((r_key_held & w_key_bit) != {NUM_KEYS{1'b0}});
        w_push       = w_do_press || w_do_release;
        w_push_data  = {w_do_release, w_hit.idx};
    end

    // FSM state, held keys and one-cycle pulses
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_state       <= S_IDLE;
            r_key_held    <= {NUM_KEYS{1'b0}};
            r_key_press   <= {NUM_KEYS{1'b0}};
            r_key_release <= {NUM_KEYS{1'b0}};
        end else begin
            r_state       <= w_nxt_state;
            r_key_press   <= w_do_press   ? w_key_bit : {NUM_KEYS{1'b0}};
            r_key_release <= w_do_release ? w_key_bit : {NUM_KEYS{1'b0}};
            if (w_do_press) begin
                r_key_held <= r_key_held | w_key_bit;
            end else if (w_do_release) begin
                r_key_held <= r_key_held & ~w_key_bit;
            end
        end
    end

    // Prefix timeout: cleared by any byte, runs only while a prefix is pending
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_tmo_cnt <= {CW{1'b0}};
        end else if (w_byte) begin
            r_tmo_cnt <= {CW{1'b0}};
        end else if (r_state != S_IDLE) begin
            if (w_tmo) begin
                r_tmo_cnt <= {CW{1'b0}};
            end else begin
                r_tmo_cnt <= r_tmo_cnt + CW'(1);
            end
        end else begin
            r_tmo_cnt <= {CW{1'b0}};
        end
    end

    kbd_event_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (CLK),
        .i_rst_n     (RESETN),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (bus.event_ready),
        .o_valid     (w_fifo_valid),
        .o_data      (w_fifo_data),
        .o_overflow  (w_fifo_ovf)
    );

    assign bus.key_held    = r_key_held;
    assign bus.key_press   = r_key_press;
    assign bus.key_release = r_key_release;
    assign bus.event_valid = w_fifo_valid;
    assign bus.event_data  = w_fifo_data;
    assign bus.overflow    = w_fifo_ovf;

endmodule

// File: tb/tb_kbd_key_decoder.sv
// Directed bench for kbd_key_decoder with an expected-event scoreboard.
module tb_kbd_key_decoder;

    localparam int TMO = 20;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [4:0] exp_q [$];

    kbd_key_decoder_if bus ();

    kbd_key_decoder #(
        .TIMEOUT    (TMO),
        .FIFO_DEPTH (4)
    ) dut (
        .CLK    (clk),
        .RESETN (rstn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one byte for exactly one cycle; returns #1 after the consuming edge
    task automatic put(input logic [7:0] b);
        bus.code_in = b;
        @(posedge clk);
        #1;
        bus.code_in = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pop everything, comparing each head against the scoreboard
    task automatic drain(input string tag);
        int guard;
        logic [4:0] e;
        bus.event_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            if (bus.event_valid) begin
                e = exp_q.pop_front();
                chk({tag, "_evt"}, 32'(bus.event_data), 32'(e));
            end
            @(posedge clk);
            #1;
            guard++;
        end
        if (exp_q.size() != 0) begin
            chk({tag, "_evt_timeout"}, 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        bus.event_ready = 1'b0;
        chk({tag, "_empty"}, 32'(bus.event_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.code_in     = 8'h00;
        bus.event_ready = 1'b0;
        rstn            = 1'b0;
        idle(3);
        rstn = 1'b1;

        // Reset state
        chk("rst_held",  32'(bus.key_held),    32'h0);
        chk("rst_press", 32'(bus.key_press),   32'h0);
        chk("rst_rel",   32'(bus.key_release), 32'h0);
        chk("rst_valid", 32'(bus.event_valid), 32'h0);
        chk("rst_data",  32'(bus.event_data),  32'h0);
        chk("rst_ovf",   32'(bus.overflow),    32'h0);

        // w make / break
        put(8'h1D);
        exp_q.push_back(5'h04);
        chk("w_press", 32'(bus.key_press), 32'h010);
        chk("w_held",  32'(bus.key_held),  32'h010);
        chk("w_valid", 32'(bus.event_valid), 32'h1);
        idle(1);
        chk("w_press_pulse", 32'(bus.key_press), 32'h0);
        put(8'hF0);
        put(8'h1D);
        exp_q.push_back(5'h14);
        chk("w_rel",      32'(bus.key_release), 32'h010);
        chk("w_held_clr", 32'(bus.key_held),    32'h0);
        idle(1);
        chk("w_rel_pulse", 32'(bus.key_release), 32'h0);
        drain("w");

        // Extended up vs keypad 8
        put(8'hE0);
        put(8'h75);
        exp_q.push_back(5'h00);
        chk("up_held",  32'(bus.key_held),  32'h001);
        chk("up_press", 32'(bus.key_press), 32'h001);
        put(8'h75);
        chk("kp_held",  32'(bus.key_held),  32'h001);
        chk("kp_press", 32'(bus.key_press), 32'h0);
        put(8'hE0);
        put(8'hF0);
        put(8'h75);
        exp_q.push_back(5'h10);
        chk("up_rel",      32'(bus.key_release), 32'h001);
        chk("up_held_clr", 32'(bus.key_held),    32'h0);
        drain("up");

        // Typematic a
        put(8'h1C);
        exp_q.push_back(5'h05);
        chk("a_press1", 32'(bus.key_press), 32'h020);
        put(8'h1C);
        chk("a_press2", 32'(bus.key_press), 32'h0);
        put(8'h1C);
        chk("a_press3", 32'(bus.key_press), 32'h0);
        chk("a_held",   32'(bus.key_held),  32'h020);
        put(8'hF0);
        put(8'h1C);
        exp_q.push_back(5'h15);
        chk("a_rel", 32'(bus.key_release), 32'h020);
        drain("a");

        // Prefix still pending just before the timeout
        put(8'hE0);
        idle(TMO - 2);
        put(8'h75);
        exp_q.push_back(5'h00);
        chk("pre_tmo_press", 32'(bus.key_press), 32'h001);
        put(8'hE0);
        put(8'hF0);
        put(8'h75);
        exp_q.push_back(5'h10);
        chk("pre_tmo_held", 32'(bus.key_held), 32'h0);
        drain("pre_tmo");

        // Prefix abandoned after TIMEOUT silent cycles
        put(8'hE0);
        idle(TMO);
        put(8'h75);
        chk("tmo_held",  32'(bus.key_held),  32'h0);
        chk("tmo_press", 32'(bus.key_press), 32'h0);
        drain("tmo");

        // Overflow with consumer stalled
        put(8'h1D);
        put(8'h1C);
        put(8'h1B);
        put(8'h23);
        exp_q.push_back(5'h04);
        exp_q.push_back(5'h05);
        exp_q.push_back(5'h06);
        exp_q.push_back(5'h07);
        chk("full_no_ovf", 32'(bus.overflow), 32'h0);
        put(8'h4B);
        chk("ovf_set",  32'(bus.overflow), 32'h1);
        chk("ovf_held", 32'(bus.key_held), 32'h1F0);
        chk("ovf_head", 32'(bus.event_data), 32'(exp_q.pop_front()));
        // Pop and push together while full
        bus.event_ready = 1'b1;
        put(8'h21);
        bus.event_ready = 1'b0;
        exp_q.push_back(5'h09);
        chk("pp_press", 32'(bus.key_press), 32'h200);
        chk("pp_valid", 32'(bus.event_valid), 32'h1);
        chk("pp_head",  32'(bus.event_data), 32'h05);
        drain("ovf");
        chk("ovf_sticky", 32'(bus.overflow), 32'h1);

        // Reset in the middle of a prefix sequence, with a byte presented
        put(8'hF0);
        put(8'h1D);
        chk("pre_rst_held", 32'(bus.key_held), 32'h3E0);
        put(8'hE0);
        put(8'hF0);
        rstn = 1'b0;
        put(8'h1D);
        rstn = 1'b1;
        chk("mrst_held",  32'(bus.key_held),    32'h0);
        chk("mrst_press", 32'(bus.key_press),   32'h0);
        chk("mrst_rel",   32'(bus.key_release), 32'h0);
        chk("mrst_valid", 32'(bus.event_valid), 32'h0);
        chk("mrst_data",  32'(bus.event_data),  32'h0);
        chk("mrst_ovf",   32'(bus.overflow),    32'h0);
        put(8'h74);
        chk("mrst_74_held",  32'(bus.key_held),    32'h0);
        chk("mrst_74_valid", 32'(bus.event_valid), 32'h0);
        put(8'h1D);
        exp_q.push_back(5'h04);
        chk("mrst_w_press", 32'(bus.key_press), 32'h010);
        drain("mrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
